ecc_sed_enc_arbiter: RTL and testbench
======================================

// Module: ecc_sed_enc_arbiter
// PURPOSE
//   Shares one single-error-detect (SED) parity encoder between NUM_REQ requesters.
//   Round-robin arbitration picks one requester per cycle.
//   The winner's 12-bit word is encoded into a 13-bit codeword: {parity, data}.
//   The codeword is held in a one-deep output register with valid/ready backpressure.
//   Sits between the requesting client ports and the single downstream storage/link port.
// PARAMETERS
//   NUM_REQ   4    number of requesters (2..8)
//   DATA_W    12   data word width; codeword width is DATA_W+1
//   CNT_W     16   width of the saturating accepted-word counter
// PORTS
//   clk           in   1                clock, all state on rising edge
//   rst           in   1                asynchronous, active-high reset
//   req_valid     in   NUM_REQ          requester i has a word
//   req_data      in   NUM_REQ*DATA_W   word of requester i at [i*DATA_W +: DATA_W]
//   req_ready     out  NUM_REQ          one-hot (or zero): requester i accepted this cycle
//   out_valid     out  1                out_codeword/out_src valid
//   out_ready     in   1                downstream consumes when out_valid && out_ready
//   out_codeword  out  DATA_W+1         {parity, data}
//   out_src       out  $clog2(NUM_REQ)  index of requester that produced out_codeword
//   enc_count     out  CNT_W            number of accepted words, saturating
// BEHAVIOUR
//   Reset (async, immediate)
//     - out_valid=0, out_codeword=0, out_src=0, enc_count=0, rr_ptr=0.
//     - Any in-flight codeword is dropped; nothing is replayed after reset.
//   Parity
//     - parity = ^data (even parity): the 13-bit codeword always has an even count of ones.
//   Slot free
//     - slot_free = !out_valid || out_ready.
//     - A same-cycle drain and refill is allowed: full throughput, 1 word/cycle.
//   Arbitration (combinational)
//     - When slot_free: the winner is the first i with req_valid[i] set, scanning
//       rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
//     - req_ready[winner]=1; every other bit is 0.
//     - When !slot_free, or no request is pending: req_ready=0.
//     - req_ready never depends on req_data.
//   Accept (req_valid[w] && req_ready[w]) at edge k
//     - Next cycle: out_valid=1, out_codeword=enc(data_w), out_src=w.
//     - Latency from accept to out_valid is exactly 1 cycle.
//     - rr_ptr <= (w+1) mod NUM_REQ.
//     - enc_count increments and holds at all-ones; it never wraps.
//   Drain without accept
//     - out_valid && out_ready with no new accept: out_valid<=0.
//     - out_codeword and out_src keep their last values.
//   Stall
//     - out_valid && !out_ready: out_codeword and out_src are held stable.
//     - No requester is granted and rr_ptr is held.
//   Idle
//     - No req_valid: rr_ptr is unchanged; no starvation.
//     - A continuously requesting source is served within NUM_REQ accepts.
//   Requester protocol
//     - A requester holds req_valid and req_data stable until it sees req_ready.
//     - The arbiter does not check this.
// STRUCTURE
//   Package ecc_sed_pkg:
//     - DATA_W and CW_W=DATA_W+1 localparams.
//     - typedef codeword_t.
//     - function sed_parity(data) returning ^data, shared with the decoder/checker.
//   Sub-module ecc_sed_parity_gen (combinational: data -> {parity, data}), instanced once on the
//   muxed winner data.
//   The round-robin pick and the output register stay in this module.
// TESTING
//   1. Reset, single requester
//      - Stimulus: rst pulse, then req_valid=4'b0001, data0=12'h001, out_ready=1.
//      - Response: req_ready=4'b0001; next cycle out_codeword=13'h1001, out_src=0, enc_count=1.
//   2. Parity corners
//      - 12'h000 -> 13'h0000; 12'h003 -> 13'h0003; 12'hFFF -> 13'h0FFF; 12'h7FF -> 13'h17FF.
//   3. All four requesting, out_ready=1
//      - Grants follow 0,1,2,3,0 on consecutive cycles.
//      - out_src follows 0,1,2,3,0, one cycle later.
//   4. Backpressure
//      - Stimulus: out_ready=0 for 5 cycles with out_valid=1.
//      - Response: codeword and src stable, req_ready=0.
//      - Stimulus: out_ready=1.
//      - Response: same-cycle refill; no bubble, no duplicate.
//   5. Reset mid-stall
//      - Stimulus: assert rst while out_valid=1.
//      - Response: out_valid drops asynchronously, enc_count=0.
//      - Stimulus: after release, requester 2 alone.
//      - Response: req_ready=4'b0100 (rr_ptr back to 0).
//   6. Saturation
//      - Stimulus: CNT_W=4, 20 accepts.
//      - Response: enc_count=4'hF and holds.

Source files
------------

// File: rtl/ecc_sed_pkg.sv
// Shared single-error-detect parity definitions, used by the encoder here and by
// the downstream decoder/checker.
package ecc_sed_pkg;

  localparam int DATA_W = 12;
  localparam int CW_W   = DATA_W + 1;

  typedef logic [CW_W-1:0] codeword_t;

  // Even parity: the resulting {parity, data} always carries an even number of ones.
  function automatic logic sed_parity(input logic [DATA_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/ecc_sed_enc_arbiter_if.sv
// Requester and downstream signals of the shared SED encoder, bundled for port use.
interface ecc_sed_enc_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 12,
  parameter int CNT_W   = 16
);
  localparam int SRC_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W:0]           out_codeword;
  logic [SRC_W-1:0]          out_src;
  logic [CNT_W-1:0]          enc_count;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_codeword, out_src, enc_count
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_codeword, out_src, enc_count
  );

endinterface

// File: rtl/ecc_sed_parity_gen.sv
// Combinational SED encoder: data -> {parity, data}.
module ecc_sed_parity_gen
  import ecc_sed_pkg::sed_parity;
#(
  parameter int DATA_W = 12
) (
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W:0]   codeword
);

  // The shared package function is fixed at its own width; other widths reduce directly.
  generate
    if (DATA_W == ecc_sed_pkg::DATA_W) begin : g_pkg
      assign codeword = {sed_parity(data), data};
    end else begin : g_generic
      assign codeword = {^data, data};
    end
  endgenerate

endmodule

// File: rtl/ecc_sed_enc_arbiter.sv
// Round-robin arbiter sharing one SED parity encoder between NUM_REQ requesters,
// with a one-deep valid/ready output register.
module ecc_sed_enc_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 12,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  ecc_sed_enc_arbiter_if.slave  bus
);

  localparam int SRC_W = $clog2(NUM_REQ);
  localparam int CW_W  = DATA_W + 1;

  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   win;
  logic               found;
  logic [NUM_REQ-1:0] grant;
  logic [DATA_W-1:0]  win_data;
  logic [CW_W-1:0]    enc_cw;
  logic               slot_free;
  int                 idx;

  logic               vld_p0;
  logic [CW_W-1:0]    cw_p0;
  logic [SRC_W-1:0]   src_p0;
  logic [CNT_W-1:0]   enc_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Draining and refilling in the same cycle keeps one word per cycle.
  assign slot_free = !vld_p0 || bus.out_ready;

  // First pending requester at or after rr_ptr, wrapping; nothing granted when the slot is busy.
  always_comb begin
    grant    = '0;
    win      = '0;
    win_data = '0;
    found    = 1'b0;
    idx      = 0;
    if (slot_free) begin
      for (int off = 0; off < NUM_REQ; off++) begin
        idx = (int'(rr_ptr) + off) % NUM_REQ;
        if (!found && bus.req_valid[idx]) begin
          found      = 1'b1;
          win        = SRC_W'(idx);
          win_data   = bus.req_data[idx*DATA_W +: DATA_W];
          grant[idx] = 1'b1;
        end
      end
    end
  end

  ecc_sed_parity_gen #(.DATA_W(DATA_W)) u_parity_gen (
    .data     (win_data),
    .codeword (enc_cw)
  );

  // Stage p0: output register; codeword/src hold across stalls and drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      cw_p0   <= '0;
      src_p0  <= '0;
      enc_cnt <= '0;
      rr_ptr  <= '0;
    end else if (found) begin
      vld_p0  <= 1'b1;
      cw_p0   <= enc_cw;
      src_p0  <= win;
      enc_cnt <= sat_inc(enc_cnt);
      rr_ptr  <= (win == SRC_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end else if (bus.out_ready) begin
      vld_p0  <= 1'b0;
    end
  end

  assign bus.req_ready    = grant;
  assign bus.out_valid    = vld_p0;
  assign bus.out_codeword = cw_p0;
  assign bus.out_src      = src_p0;
  assign bus.enc_count    = enc_cnt;

endmodule

// File: tb/tb_ecc_sed_enc_arbiter.sv
// Bench for ecc_sed_enc_arbiter: directed scenarios plus randomized traffic, checked by a
// queue scoreboard fed from a behavioural model of the arbitration and encoding rules.
module tb_ecc_sed_enc_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ecc_sed_enc_arbiter_if #(.NUM_REQ(NREQ), .DATA_W(DW), .CNT_W(16)) bus ();
  ecc_sed_enc_arbiter_if #(.NUM_REQ(NREQ), .DATA_W(DW), .CNT_W(4))  bus4 ();

  ecc_sed_enc_arbiter #(.NUM_REQ(NREQ), .DATA_W(DW), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ecc_sed_enc_arbiter #(.NUM_REQ(NREQ), .DATA_W(DW), .CNT_W(4)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference rules: expected codeword from a ones count, winner by scanning from the pointer.
  function automatic logic [12:0] exp_cw(input logic [11:0] d);
    return 13'(d) + ((13'($countones(d)) & 13'd1) << 12);
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (ptr + k) % NREQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  logic        m_valid = 1'b0;
  int          m_ptr   = 0;
  int          m_cnt   = 0;
  logic [12:0] q_cw[$];
  int          q_src[$];

  // Model advances on the same edge as the DUT; each accept pushes the expected output.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 1'b0;
      m_ptr   = 0;
      m_cnt   = 0;
      q_cw.delete();
      q_src.delete();
    end else begin
      int w;
      w = (!m_valid || bus.out_ready) ? pick(bus.req_valid, m_ptr) : -1;
      if (w >= 0) begin
        q_cw.push_back(exp_cw(bus.req_data[w*DW +: DW]));
        q_src.push_back(w);
        m_valid = 1'b1;
        m_ptr   = (w + 1) % NREQ;
        if (m_cnt < 65535) m_cnt++;
      end else if (bus.out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      int g;
      g = (!m_valid || bus.out_ready) ? pick(bus.req_valid, m_ptr) : -1;
      chk("req_ready", 32'(bus.req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
      chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("enc_count", 32'(bus.enc_count), 32'(m_cnt));
      if (bus.out_valid) begin
        if (q_cw.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_empty: out_valid=1 with no expected word at %0t", $time);
        end else begin
          chk("sb_codeword", 32'(bus.out_codeword), 32'(q_cw[0]));
          chk("sb_src", 32'(bus.out_src), 32'(q_src[0]));
          if (bus.out_ready) begin
            void'(q_cw.pop_front());
            void'(q_src.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [11:0]     d[NREQ];
  logic [11:0]     corner_in[4]  = '{12'h000, 12'h003, 12'hFFF, 12'h7FF};
  logic [12:0]     corner_out[4] = '{13'h0000, 13'h0003, 13'h0FFF, 13'h17FF};
  logic [NREQ-1:0] gr;

  initial begin
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.out_ready  = 1'b0;
    bus4.req_valid = '0;
    bus4.req_data  = '0;
    bus4.out_ready = 1'b0;

    // Reset state and single requester
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_codeword", 32'(bus.out_codeword), 32'd0);
    chk("rst_src", 32'(bus.out_src), 32'd0);
    chk("rst_count", 32'(bus.enc_count), 32'd0);
    step();
    rst = 1'b0;
    bus.req_valid = 4'b0001;
    bus.req_data[0 +: DW] = 12'h001;
    bus.out_ready = 1'b1;
    #1;
    chk("t1_req_ready", 32'(bus.req_ready), 32'h1);
    step();
    chk("t1_codeword", 32'(bus.out_codeword), 32'h1001);
    chk("t1_src", 32'(bus.out_src), 32'd0);
    chk("t1_count", 32'(bus.enc_count), 32'd1);

    // Parity corners
    for (int c = 0; c < 4; c++) begin
      bus.req_data[0 +: DW] = corner_in[c];
      step();
      chk("t2_parity", 32'(bus.out_codeword), 32'(corner_out[c]));
    end

    // All four requesting: grants rotate 0,1,2,3,0
    rst = 1'b1;
    bus.req_valid = '0;
    #2;
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      d[i] = 12'($urandom);
      bus.req_data[i*DW +: DW] = d[i];
    end
    bus.req_valid = 4'b1111;
    #1;
    for (int g = 0; g < 5; g++) begin
      chk("t3_grant", 32'(bus.req_ready), 32'd1 << (g % NREQ));
      step();
      chk("t3_src", 32'(bus.out_src), 32'(g % NREQ));
      chk("t3_codeword", 32'(bus.out_codeword), 32'(exp_cw(d[g % NREQ])));
    end

    // Backpressure: hold for 5 cycles, then same-cycle refill
    bus.out_ready = 1'b0;
    #1;
    for (int s = 0; s < 5; s++) begin
      chk("t4_stall_ready", 32'(bus.req_ready), 32'd0);
      chk("t4_stall_valid", 32'(bus.out_valid), 32'd1);
      chk("t4_stall_src", 32'(bus.out_src), 32'd0);
      chk("t4_stall_cw", 32'(bus.out_codeword), 32'(exp_cw(d[0])));
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("t4_refill_grant", 32'(bus.req_ready), 32'h2);
    step();
    chk("t4_refill_valid", 32'(bus.out_valid), 32'd1);
    chk("t4_refill_src", 32'(bus.out_src), 32'd1);
    chk("t4_refill_count", 32'(bus.enc_count), 32'd6);

    // Reset while stalled
    bus.out_ready = 1'b0;
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_rst_count", 32'(bus.enc_count), 32'd0);
    chk("t5_rst_cw", 32'(bus.out_codeword), 32'd0);
    rst = 1'b0;
    bus.req_valid = 4'b0100;
    bus.out_ready = 1'b1;
    #1;
    chk("t5_grant", 32'(bus.req_ready), 32'h4);
    step();
    chk("t5_src", 32'(bus.out_src), 32'd2);
    chk("t5_codeword", 32'(bus.out_codeword), 32'(exp_cw(d[2])));

    // Saturation on the 4-bit counter instance
    chk("t6_init", 32'(bus4.enc_count), 32'd0);
    bus4.req_data  = 48'($urandom);
    bus4.req_valid = 4'b0001;
    bus4.out_ready = 1'b1;
    for (int n = 1; n <= 25; n++) begin
      step();
      if (n == 10) chk("t6_count10", 32'(bus4.enc_count), 32'd10);
      if (n == 20) chk("t6_count20", 32'(bus4.enc_count), 32'hF);
    end
    chk("t6_hold", 32'(bus4.enc_count), 32'hF);
    bus4.req_valid = '0;

    // Randomized traffic; a requester keeps its word until granted
    gr = '0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!(bus.req_valid[i] && !gr[i])) begin
          bus.req_valid[i] = ($urandom_range(0, 99) < 60);
          bus.req_data[i*DW +: DW] = 12'($urandom);
        end
      end
      bus.out_ready = ($urandom_range(0, 99) < 70);
      #3;
      gr = bus.req_ready;
      step();
    end

    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    repeat (4) step();
    chk("drain_valid", 32'(bus.out_valid), 32'd0);
    chk("drain_queue", 32'(q_cw.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
